// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the 36-bit draw-instruction interface.
// Latency: n/a (types, constants and a combinational pack helper only).
// Backpressure: n/a.
package gpu_isa_pkg;

    typedef enum logic [1:0] {
        OP_LD   = 2'b00,
        OP_RD   = 2'b01,
        OP_CD   = 2'b10,
        OP_DISP = 2'b11
    } op_e;

    // Raster ALU function codes, one per opcode (MSB set marks a draw unit op).
    localparam logic [2:0] ALU_LD   = 3'b100;
    localparam logic [2:0] ALU_RD   = 3'b101;
    localparam logic [2:0] ALU_CD   = 3'b110;
    localparam logic [2:0] ALU_DISP = 3'b111;

    localparam int INSTR_W = 36;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int OP_LSB  = 34;
    localparam int X1_LSB  = 25;
    localparam int Y1_LSB  = 17;
    localparam int X2_LSB  = 8;
    localparam int Y2_LSB  = 0;

    localparam int X_MAX_DEF = 319;
    localparam int Y_MAX_DEF = 239;

    // DISP with all-zero coordinates doubles as the bubble word.
    localparam logic [INSTR_W-1:0] IDLE_WORD_DEF = 36'hC_0000_0000;

    typedef struct packed {
        op_e            op;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic [X_W-1:0] x2;
        logic [Y_W-1:0] y2;
    } instr_t;

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [1:0]     op,
        input logic [X_W-1:0] x1,
        input logic [Y_W-1:0] y1,
        input logic [X_W-1:0] x2,
        input logic [Y_W-1:0] y2
    );
        logic [INSTR_W-1:0] w;
        w                  = '0;
        w[OP_LSB +: 2]     = op;
        w[X1_LSB +: X_W]   = x1;
        w[Y1_LSB +: Y_W]   = y1;
        w[X2_LSB +: X_W]   = x2;
        w[Y2_LSB +: Y_W]   = y2;
        return w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with first-word fall-through head.
// Latency: a push at edge N is visible on head_dat/level after edge N.
// Backpressure: push ignored when full unless a pop happens on the same edge.
module cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: a pop frees the slot a simultaneous push needs when full.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage array; no reset needed because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == LW'(DEPTH));
    assign empty    = (cnt == '0);
    assign level    = cnt;

endmodule

// File: rtl/instruction_encoder.sv
// Clamps and packs draw commands into ISA words, queues them, issues one at a time.
// Latency: command accepted at edge N into an idle empty block issues at edge N+1.
// Backpressure: cmd_ready = !full; draw ops hold the bus until exec_done or watchdog.
module instruction_encoder
    import gpu_isa_pkg::*;
#(
    parameter int                 DEPTH     = 4,
    parameter int                 X_MAX     = X_MAX_DEF,
    parameter int                 Y_MAX     = Y_MAX_DEF,
    parameter int                 TIMEOUT   = 4096,
    parameter logic [INSTR_W-1:0] IDLE_WORD = IDLE_WORD_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [X_W-1:0]           cmd_x1,
    input  logic [Y_W-1:0]           cmd_y1,
    input  logic [X_W-1:0]           cmd_x2,
    input  logic [Y_W-1:0]           cmd_y2,
    output logic [INSTR_W-1:0]       instruction,
    output logic                     instr_valid,
    input  logic                     exec_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_range,
    output logic                     err_timeout
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUBBLE,
        S_WAIT_DONE
    } state_e;

    state_e             state;
    state_e             state_nxt;
    logic [INSTR_W-1:0] enc_word;
    logic [INSTR_W-1:0] fifo_head;
    logic [INSTR_W-1:0] last_word;
    instr_t             head_s;
    logic [X_W-1:0]     x1_c;
    logic [X_W-1:0]     x2_c;
    logic [Y_W-1:0]     y1_c;
    logic [Y_W-1:0]     y2_c;
    logic               clamped;
    logic               push;
    logic               pop;
    logic               issue;
    logic               load_bubble;
    logic               wd_abort;
    logic               wd_expired;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WD_W-1:0]    wd_cnt;

    // Clamp coordinates to the screen and pack; DISP carries no coordinates.
    always_comb begin
        x1_c    = (cmd_x1 > X_W'(X_MAX)) ? X_W'(X_MAX) : cmd_x1;
        x2_c    = (cmd_x2 > X_W'(X_MAX)) ? X_W'(X_MAX) : cmd_x2;
        y1_c    = (cmd_y1 > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : cmd_y1;
        y2_c    = (cmd_y2 > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : cmd_y2;
        clamped = (cmd_x1 > X_W'(X_MAX)) || (cmd_x2 > X_W'(X_MAX)) ||
                  (cmd_y1 > Y_W'(Y_MAX)) || (cmd_y2 > Y_W'(Y_MAX));
        if (cmd_op == OP_DISP) begin
            x1_c    = '0;
            x2_c    = '0;
            y1_c    = '0;
            y2_c    = '0;
            clamped = 1'b0;
        end
        enc_word = pack_instr(cmd_op, x1_c, y1_c, x2_c, y2_c);
    end

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign head_s    = instr_t'(fifo_head);

    cmd_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (enc_word),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Issue sequencing: repeated words get an IDLE_WORD bubble so the decoder sees a change.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        issue       = 1'b0;
        load_bubble = 1'b0;
        wd_abort    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (fifo_head != last_word) begin
                        pop   = 1'b1;
                        issue = 1'b1;
                    end else begin
                        load_bubble = 1'b1;
                        state_nxt   = S_BUBBLE;
                    end
                end
            end
            S_BUBBLE: begin
                pop   = 1'b1;
                issue = 1'b1;
            end
            S_WAIT_DONE: begin
                if (exec_done) begin
                    state_nxt = S_IDLE;
                end else if (wd_expired) begin
                    wd_abort  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // The decoder never acknowledges DISP, so only draw ops wait.
        if (issue) begin
            state_nxt = (head_s.op == OP_DISP) ? S_IDLE : S_WAIT_DONE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Watchdog counts consecutive cycles spent waiting for exec_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT_DONE && state_nxt == S_WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // Registered bus, strobes and last-issued word; an abort forgets the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= IDLE_WORD;
            last_word   <= IDLE_WORD;
            instr_valid <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            instr_valid <= issue;
            err_range   <= push && clamped;
            err_timeout <= wd_abort;
            if (issue) begin
                instruction <= fifo_head;
                last_word   <= fifo_head;
            end else if (load_bubble) begin
                instruction <= IDLE_WORD;
            end
            if (wd_abort) begin
                last_word <= IDLE_WORD;
            end
        end
    end

    assign busy = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized plus directed bench against a transaction-level scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_encoder;

    localparam int          DEPTH  = 4;
    localparam int          TO     = 8;
    localparam logic [35:0] IDLE_W = 36'hC_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [8:0]  cmd_x1 = 9'd0;
    logic [7:0]  cmd_y1 = 8'd0;
    logic [8:0]  cmd_x2 = 9'd0;
    logic [7:0]  cmd_y2 = 8'd0;
    logic [35:0] instruction;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        err_range;
    logic        err_timeout;

    always #5 clk = ~clk;

    instruction_encoder #(
        .DEPTH     (DEPTH),
        .X_MAX     (319),
        .Y_MAX     (239),
        .TIMEOUT   (TO),
        .IDLE_WORD (IDLE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x1      (cmd_x1),
        .cmd_y1      (cmd_y1),
        .cmd_x2      (cmd_x2),
        .cmd_y2      (cmd_y2),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .err_range   (err_range),
        .err_timeout (err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard state: queued words, whether a draw is outstanding, etc.
    logic [35:0] q[$];
    logic [35:0] last_w = IDLE_W;
    logic [35:0] prev_instr = IDLE_W;
    bit          outstanding = 1'b0;
    int          wcnt = 0;
    bit          saw_idle = 1'b1;
    int          n_issued = 0;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [35:0] ref_word(input logic [1:0] op, input int x1, input int y1,
                                              input int x2, input int y2);
        longint w;
        if (op == 2'b11) begin
            w = longint'(3) * (longint'(1) << 34);
        end else begin
            w = longint'(op) * (longint'(1) << 34)
              + longint'(clampv(x1, 319)) * (longint'(1) << 25)
              + longint'(clampv(y1, 239)) * (longint'(1) << 17)
              + longint'(clampv(x2, 319)) * 256
              + longint'(clampv(y2, 239));
        end
        return 36'(w);
    endfunction

    function automatic bit ref_clamped(input logic [1:0] op, input int x1, input int y1,
                                       input int x2, input int y2);
        return (op != 2'b11) && (x1 > 319 || x2 > 319 || y1 > 239 || y2 > 239);
    endfunction

    task automatic model_clear();
        q.delete();
        last_w      = IDLE_W;
        prev_instr  = IDLE_W;
        outstanding = 1'b0;
        wcnt        = 0;
        saw_idle    = 1'b1;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [8:0] x1, input logic [7:0] y1,
                           input logic [8:0] x2, input logic [7:0] y2);
        cmd_op    = op;
        cmd_x1    = x1;
        cmd_y1    = y1;
        cmd_x2    = x2;
        cmd_y2    = y2;
        cmd_valid = 1'b1;
    endtask

    // One clock: capture inputs, take the edge, check outputs #1 later against the model.
    task automatic step();
        bit          acc;
        bit          ex;
        bit          ov;
        bit          exp_rng;
        bit          exp_to;
        logic [35:0] w;
        logic [35:0] head;
        acc     = cmd_valid && cmd_ready;
        ex      = exec_done;
        w       = ref_word(cmd_op, int'(cmd_x1), int'(cmd_y1), int'(cmd_x2), int'(cmd_y2));
        exp_rng = acc && ref_clamped(cmd_op, int'(cmd_x1), int'(cmd_y1), int'(cmd_x2), int'(cmd_y2));
        @(posedge clk);
        #1;
        exp_to = 1'b0;
        ov     = outstanding;
        if (outstanding) begin
            if (ex) begin
                outstanding = 1'b0;
            end else begin
                wcnt++;
                if (wcnt == TO) begin
                    exp_to      = 1'b1;
                    outstanding = 1'b0;
                    last_w      = IDLE_W;
                end
            end
        end
        if (instr_valid) begin
            chk("issue_while_waiting", 36'(instr_valid & ov), 36'd0);
            if (q.size() == 0) begin
                chk("issue_from_empty", 36'(instr_valid), 36'd0);
            end else begin
                head = q.pop_front();
                n_issued++;
                chk("issue_word", instruction, head);
                if (head == last_w) begin
                    chk("bubble_seen", 36'(saw_idle), 36'd1);
                end
                last_w   = head;
                saw_idle = 1'b0;
                if (head[35:34] != 2'b11) begin
                    outstanding = 1'b1;
                    wcnt        = 0;
                end
            end
        end else begin
            chk("instr_hold", 36'(instruction == prev_instr || instruction == IDLE_W), 36'd1);
            if (instruction == IDLE_W) begin
                saw_idle = 1'b1;
            end
        end
        prev_instr = instruction;
        if (acc) begin
            q.push_back(w);
            cmd_valid = 1'b0;
        end
        chk("err_range", 36'(err_range), 36'(exp_rng));
        chk("err_timeout", 36'(err_timeout), 36'(exp_to));
        chk("fifo_level", 36'(fifo_level), 36'(q.size()));
        chk("cmd_ready", 36'(cmd_ready), 36'(q.size() < DEPTH));
        chk("busy", 36'(busy), 36'((q.size() != 0) || outstanding));
    endtask

    // Completes every draw immediately until everything has drained (bounded).
    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !outstanding && !cmd_valid) begin
                break;
            end
            exec_done = outstanding;
            step();
        end
        exec_done = 1'b0;
        chk(tag, 36'(busy), 36'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        int n0;
        bit got;

        // Reset values
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instruction", instruction, IDLE_W);
        chk("rst_instr_valid", 36'(instr_valid), 36'd0);
        chk("rst_level", 36'(fifo_level), 36'd0);
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_ready", 36'(cmd_ready), 36'd1);
        chk("rst_errs", 36'({err_range, err_timeout}), 36'd0);
        reset = 1'b0;
        model_clear();

        // 1: LD issues one cycle after acceptance and holds until exec_done
        set_cmd(2'd0, 9'd10, 8'd20, 9'd100, 8'd200);
        step();
        step();
        chk("t1_word", instruction, 36'h0_1428_64C8);
        chk("t1_valid", 36'(instr_valid), 36'd1);
        repeat (4) step();
        chk("t1_hold", instruction, 36'h0_1428_64C8);
        chk("t1_busy", 36'(busy), 36'd1);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        step();

        // 2: clamping of x2/y2, and exact-limit coordinates do not flag
        set_cmd(2'd1, 9'd5, 8'd6, 9'd400, 8'd250);
        step();
        chk("t2_err_range", 36'(err_range), 36'd1);
        set_cmd(2'd0, 9'd319, 8'd239, 9'd0, 8'd0);
        step();
        chk("t2_word", instruction, 36'h4_0A0D_3FEF);
        chk("t2_limit_no_err", 36'(err_range), 36'd0);
        drain("t2_drain", 40);

        // 3: five back-to-back pushes with no exec_done, sixth stalls
        for (int i = 0; i < 5; i++) begin
            set_cmd(2'd1, 9'(i + 1), 8'(i + 2), 9'(i + 3), 8'(i + 4));
            step();
        end
        set_cmd(2'd2, 9'd77, 8'd66, 9'd55, 8'd44);
        step();
        step();
        chk("t3_full_level", 36'(fifo_level), 36'd4);
        chk("t3_ready_low", 36'(cmd_ready), 36'd0);
        drain("t3_drain", 60);

        // 4: identical CD commands both issue, with a bubble in between
        n0 = n_issued;
        set_cmd(2'd2, 9'd50, 8'd60, 9'd20, 8'd0);
        step();
        set_cmd(2'd2, 9'd50, 8'd60, 9'd20, 8'd0);
        step();
        drain("t4_drain", 40);
        chk("t4_both_issued", 36'(n_issued - n0), 36'd2);

        // 5: DISP issues the cycle after LD's exec_done and does not wait
        set_cmd(2'd0, 9'd1, 8'd2, 9'd3, 8'd4);
        step();
        set_cmd(2'd3, 9'd400, 8'd9, 9'd9, 8'd9);
        step();
        chk("t5_disp_no_err", 36'(err_range), 36'd0);
        step();
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk("t5_no_early_issue", 36'(instr_valid), 36'd0);
        step();
        chk("t5_disp_valid", 36'(instr_valid), 36'd1);
        chk("t5_disp_word", instruction, 36'hC_0000_0000);
        chk("t5_idle", 36'(busy), 36'd0);

        // 6: watchdog aborts after TO cycles, next command then issues
        set_cmd(2'd0, 9'd7, 8'd7, 9'd7, 8'd7);
        step();
        step();
        chk("t6_issue", 36'(instr_valid), 36'd1);
        k   = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            k++;
            got = err_timeout;
        end
        chk("t6_timeout_delay", 36'(k), 36'd8);
        set_cmd(2'd1, 9'd9, 8'd9, 9'd9, 8'd9);
        step();
        step();
        chk("t6_next_issue", 36'(instr_valid), 36'd1);
        set_cmd(2'd2, 9'd3, 8'd3, 9'd3, 8'd3);
        step();
        step();
        // Reset mid-wait with a command queued
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_instruction", instruction, IDLE_W);
        chk("t6_rst_level", 36'(fifo_level), 36'd0);
        chk("t6_rst_busy", 36'(busy), 36'd0);
        chk("t6_rst_flags", 36'({instr_valid, err_range, err_timeout}), 36'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        repeat (3) step();

        // Randomized traffic: clamping, repeats, DISP, late/missing exec_done
        for (int i = 0; i < 1500; i++) begin
            if (!cmd_valid && $urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    cmd_valid = 1'b1;
                end else begin
                    set_cmd(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)),
                            8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
                            8'($urandom_range(0, 255)));
                end
            end
            exec_done = outstanding ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            step();
        end
        drain("rand_drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
